// File: rtl/memoria_escrita.sv
// memoria_escrita
// Write-once-then-read buffer. Words presented on the sink side are appended
// at address wr_count until the buffer holds ADDRESS_WIDTH words. A clear
// rewinds the write pointer without touching the stored data. Any stored word
// can be read back at any time with one cycle of latency.
//
// Parameters
//   ADDRESS_WIDTH  number of stored words (depth), at most 255
//   DATA_WIDTH     width of each stored word
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous reset, active low
//   sink_data   word to store
//   sink_valid  sink_data is valid
//   sink_ready  block accepts a word this cycle (combinational)
//   sink_cen    chip enable; no word is accepted while low
//   clear       rewinds the write pointer and clears overflow at the next edge
//   rd_address  readback address
//   src_data    registered readback word, zero for addresses past the depth
//   wr_count    number of words stored
//   full        wr_count equals the depth
//   overflow    sticky: a write was attempted while full
module memoria_escrita #(
  parameter int unsigned ADDRESS_WIDTH = 200,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sink_data,
  input  logic                  sink_valid,
  output logic                  sink_ready,
  input  logic                  sink_cen,
  input  logic                  clear,
  input  logic [7:0]            rd_address,
  output logic [DATA_WIDTH-1:0] src_data,
  output logic [7:0]            wr_count,
  output logic                  full,
  output logic                  overflow
);

  localparam logic [7:0] DEPTH    = 8'(ADDRESS_WIDTH);
  localparam logic [7:0] LAST_IDX = 8'(ADDRESS_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FULL
  } stateT;

  stateT                 r_state;
  stateT                 w_nextState;
  logic [7:0]            r_wrCount;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_srcData;
  logic                  w_transfer;
  logic [DATA_WIDTH-1:0] r_mem [0:ADDRESS_WIDTH-1];

  // The handshake is open only in ACTIVE. sink_cen is also gated here
  // because ACTIVE reflects the enable seen at the previous edge, and a word
  // must never be taken on a cycle where the enable has already dropped.
  // Reset forces r_state to IDLE asynchronously, so ready falls with it.
  assign sink_ready = (r_state == ACTIVE) & sink_cen & ~clear;
  assign w_transfer = sink_valid & sink_ready;

  assign wr_count = r_wrCount;
  assign full     = (r_wrCount == DEPTH);
  assign overflow = r_overflow;
  assign src_data = r_srcData;

  // Next-state logic. FULL is left only through clear; the transfer that
  // fills the last slot goes straight to FULL, ahead of any enable change.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (sink_cen) w_nextState = ACTIVE;
      end
      ACTIVE: begin
        if (w_transfer && (r_wrCount == LAST_IDX)) w_nextState = FULL;
        else if (!sink_cen)                        w_nextState = IDLE;
      end
      FULL: begin
        if (clear) w_nextState = sink_cen ? ACTIVE : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State, write pointer and sticky overflow. Clear wins over everything,
  // including a write attempt in the same cycle. The pointer cannot pass the
  // depth because sink_ready is low once FULL is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wrCount  <= 8'd0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (clear) begin
        r_wrCount  <= 8'd0;
        r_overflow <= 1'b0;
      end else if (w_transfer) begin
        r_wrCount <= r_wrCount + 8'd1;
      end else if ((r_state == FULL) && sink_valid && sink_cen) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage array. Deliberately not reset so its contents survive both
  // reset and clear.
  always_ff @(posedge clk) begin
    if (w_transfer) r_mem[r_wrCount] <= sink_data;
  end

  // Registered readback. Non-blocking update of r_mem means a read and a
  // write to the same address on one edge return the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_srcData <= '0;
    end else if (rd_address < DEPTH) begin
      r_srcData <= r_mem[rd_address];
    end else begin
      r_srcData <= '0;
    end
  end

endmodule

// File: tb/tb_memoria_escrita.sv
// tb_memoria_escrita
// Directed bench for memoria_escrita. A behavioural model (array plus counter)
// predicts every output and is compared against the DUT on each falling edge;
// literal expectations at key points pin the model down.
module tb_memoria_escrita;

  localparam int DEPTH = 200;

  logic        clk;
  logic        reset;
  logic [31:0] sink_data;
  logic        sink_valid;
  logic        sink_ready;
  logic        sink_cen;
  logic        clear;
  logic [7:0]  rd_address;
  logic [31:0] src_data;
  logic [7:0]  wr_count;
  logic        full;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 0;

  // Model state: stored words with a known-bit each, pointer, overflow,
  // whether the enable was high at the last edge, and the expected readback.
  logic [31:0] mMem [0:DEPTH-1];
  bit          mKnown [0:DEPTH-1];
  int          mCount = 0;
  bit          mOvf = 0;
  bit          mEn = 0;
  logic [31:0] mSrc = 32'd0;
  bit          mSrcKnown = 1;

  memoria_escrita #(
    .ADDRESS_WIDTH(DEPTH),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sink_data(sink_data),
    .sink_valid(sink_valid),
    .sink_ready(sink_ready),
    .sink_cen(sink_cen),
    .clear(clear),
    .rd_address(rd_address),
    .src_data(src_data),
    .wr_count(wr_count),
    .full(full),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, and return shortly
  // after it so outputs can be read away from the edge.
  task automatic applyStimulus(input logic cen, input logic valid, input logic clr,
                               input logic [31:0] data, input logic [7:0] addr);
    sink_cen   = cen;
    sink_valid = valid;
    clear      = clr;
    sink_data  = data;
    rd_address = addr;
    @(posedge clk);
    #2;
  endtask

  // Behavioural model: a word is taken when the enable was seen at the last
  // edge, is still high, no clear, and there is room. Reads see the array
  // before this edge's write.
  always @(posedge clk or negedge reset) begin
    bit acc;
    if (!reset) begin
      mCount    = 0;
      mOvf      = 0;
      mEn       = 0;
      mSrc      = 32'd0;
      mSrcKnown = 1;
    end else begin
      acc = mEn && sink_cen && !clear && (mCount < DEPTH);
      if (int'(rd_address) < DEPTH) begin
        mSrc      = mMem[rd_address];
        mSrcKnown = mKnown[rd_address];
      end else begin
        mSrc      = 32'd0;
        mSrcKnown = 1;
      end
      if (clear) begin
        mCount = 0;
        mOvf   = 0;
      end else if (acc && sink_valid) begin
        mMem[mCount]   = sink_data;
        mKnown[mCount] = 1;
        mCount++;
      end else if ((mCount == DEPTH) && sink_valid && sink_cen) begin
        mOvf = 1;
      end
      mEn = sink_cen;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit expReady;
    if (checkEn) begin
      expReady = reset && mEn && sink_cen && !clear && (mCount < DEPTH);
      checkOutput("wr_count", 64'(wr_count), 64'(mCount));
      checkOutput("full", 64'(full), 64'(mCount == DEPTH));
      checkOutput("overflow", 64'(overflow), 64'(mOvf));
      checkOutput("sink_ready", 64'(sink_ready), 64'(expReady));
      if (mSrcKnown) checkOutput("src_data", 64'(src_data), 64'(mSrc));
    end
  end

  initial begin
    logic [31:0] expWords [0:6];
    expWords[0] = 32'hC0; expWords[1] = 32'hC1; expWords[2] = 32'hC2;
    expWords[3] = 32'hA5A5A5A5;
    expWords[4] = 32'h70; expWords[5] = 32'h71; expWords[6] = 32'h72;

    reset = 1'b0; sink_cen = 0; sink_valid = 0; clear = 0;
    sink_data = 32'd0; rd_address = 8'd0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_wr_count", 64'(wr_count), 64'd0);
    checkOutput("rst_src_data", 64'(src_data), 64'd0);
    checkOutput("rst_sink_ready", 64'(sink_ready), 64'd0);
    checkOutput("rst_full", 64'(full), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    reset   = 1'b1;
    checkEn = 1;

    // Basic write and readback
    applyStimulus(1, 0, 0, 32'd0, 8'd0);
    applyStimulus(1, 1, 0, 32'hDEADBEEF, 8'd0);
    applyStimulus(1, 1, 0, 32'h00000001, 8'd0);
    applyStimulus(1, 0, 0, 32'd0, 8'd0);
    checkOutput("basic_count", 64'(wr_count), 64'd2);
    checkOutput("basic_rd0", 64'(src_data), 64'hDEADBEEF);
    applyStimulus(1, 0, 0, 32'd0, 8'd1);
    checkOutput("basic_rd1", 64'(src_data), 64'h1);

    // Chip enable low: nothing accepted, reads still work
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 32'hBAD00000 | 32'(i), 8'(i % 2));
    checkOutput("cen_ready", 64'(sink_ready), 64'd0);
    checkOutput("cen_count", 64'(wr_count), 64'd2);
    checkOutput("cen_rd1", 64'(src_data), 64'h1);

    // Clear takes priority over a simultaneous write
    applyStimulus(1, 0, 0, 32'd0, 8'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 32'(32'h100 + i), 8'd0);
    checkOutput("clr_pre_count", 64'(wr_count), 64'd5);
    applyStimulus(1, 1, 1, 32'h00000BAD, 8'd0);
    checkOutput("clr_count", 64'(wr_count), 64'd0);
    checkOutput("clr_overflow", 64'(overflow), 64'd0);
    checkOutput("clr_mem_kept", 64'(src_data), 64'hDEADBEEF);
    applyStimulus(1, 1, 0, 32'h55, 8'd0);
    applyStimulus(1, 0, 0, 32'd0, 8'd0);
    checkOutput("clr_next_addr0", 64'(src_data), 64'h55);
    checkOutput("clr_next_count", 64'(wr_count), 64'd1);

    // Fill to full, then overflow
    applyStimulus(1, 0, 1, 32'd0, 8'd0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1, 0, 32'(i), 8'(i));
    checkOutput("fill_full", 64'(full), 64'd1);
    checkOutput("fill_ready", 64'(sink_ready), 64'd0);
    checkOutput("fill_count", 64'(wr_count), 64'd200);
    checkOutput("fill_ovf_pre", 64'(overflow), 64'd0);
    applyStimulus(1, 1, 0, 32'hFFFFFFFF, 8'd199);
    checkOutput("fill_ovf", 64'(overflow), 64'd1);
    checkOutput("fill_count_hold", 64'(wr_count), 64'd200);
    checkOutput("fill_rd199", 64'(src_data), 64'd199);
    applyStimulus(0, 0, 0, 32'd0, 8'd3);
    checkOutput("fill_rd3", 64'(src_data), 64'd3);
    checkOutput("fill_ovf_sticky", 64'(overflow), 64'd1);

    // Read-before-write on address 3, and out-of-range read
    applyStimulus(1, 0, 1, 32'd0, 8'd0);
    checkOutput("rbw_clr_ovf", 64'(overflow), 64'd0);
    checkOutput("rbw_clr_full", 64'(full), 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 32'(32'hC0 + i), 8'd0);
    applyStimulus(1, 1, 0, 32'hA5A5A5A5, 8'd3);
    checkOutput("rbw_old", 64'(src_data), 64'd3);
    checkOutput("rbw_count", 64'(wr_count), 64'd4);
    applyStimulus(1, 0, 0, 32'd0, 8'd3);
    checkOutput("rbw_new", 64'(src_data), 64'hA5A5A5A5);
    applyStimulus(1, 0, 0, 32'd0, 8'd250);
    checkOutput("oor_read", 64'(src_data), 64'd0);

    // Asynchronous reset between edges during a transfer
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 32'(32'h70 + i), 8'd2);
    checkOutput("arst_pre_count", 64'(wr_count), 64'd7);
    sink_valid = 1; sink_data = 32'hDEAD0007; rd_address = 8'd2;
    #1;
    reset = 1'b0;
    #1;
    checkOutput("arst_count", 64'(wr_count), 64'd0);
    checkOutput("arst_src", 64'(src_data), 64'd0);
    checkOutput("arst_ready", 64'(sink_ready), 64'd0);
    checkOutput("arst_full", 64'(full), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    applyStimulus(1, 1, 0, 32'hDEAD0008, 8'd0);
    checkOutput("arst_post_count", 64'(wr_count), 64'd0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 32'd0, 8'(i));
      checkOutput("arst_mem_kept", 64'(src_data), 64'(expWords[i]));
    end

    checkEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
